// File: rtl/data_memory_port.sv
// Load/store access controller for a byte-addressed, little-endian 32-bit data memory.
// Handles sub-word loads with extension, and performs sub-word stores as a read-modify-write.
module data_memory_port #(
  parameter int unsigned ADDR_LIMIT = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [2:0]  width;
  logic        misaligned;
  logic        out_of_range;
  logic        bad_req;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    unique case (size_i)
      2'b00:   width = 3'd1;
      2'b01:   width = 3'd2;
      default: width = 3'd4;
    endcase
  end

  assign misaligned   = ((size_i == 2'b01) && addr_i[0]) ||
                        ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
  // 33-bit sum so addresses near 2^32 cannot wrap back into range
  assign out_of_range = ({1'b0, addr_i} + {30'b0, width}) > 33'(ADDR_LIMIT);
  assign bad_req      = misaligned || out_of_range || (size_i == 2'b11);

  assign byte_sh = {addr_q[1:0], 3'b000};
  assign half_sh = {addr_q[1], 4'b0000};
  assign rd_byte = 8'(mem_data_i >> byte_sh);
  assign rd_half = 16'(mem_data_i >> half_sh);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          we_d   = we_i;
          size_d = size_i;
          uns_d  = unsigned_i;
          addr_d = addr_i;
          data_d = wdata_i;
          err_d  = bad_req;
          if (bad_req) begin
            state_d = StDone;
          end else if (we_i && (size_i == 2'b10)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (we_q) begin
          if (size_q == 2'b00) begin
            data_d = (mem_data_i & ~(32'h0000_00ff << byte_sh)) |
                     ({24'b0, data_q[7:0]} << byte_sh);
          end else begin
            data_d = (mem_data_i & ~(32'h0000_ffff << half_sh)) |
                     ({16'b0, data_q[15:0]} << half_sh);
          end
          state_d = StWr;
        end else begin
          unique case (size_q)
            2'b00:   rdata_d = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   rdata_d = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rdata_d = mem_data_i;
          endcase
          state_d = StDone;
        end
      end
      StWr:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'b0;
      data_q  <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign err_o       = (state_q == StDone) && err_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_data_o  = data_q;
  assign mem_read_o  = (state_q == StRd);
  assign mem_write_o = (state_q == StWr);

endmodule

// File: tb/tb_data_memory_port.sv
// Directed bench for data_memory_port with a behavioural 128-byte memory attached.
module tb_data_memory_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'b0;
  logic [31:0] wdata = 32'b0;
  logic        busy, done, err, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:31];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_idx = 5'd0;
  logic [31:0] pre_val = 32'b0;

  int n_checks = 0;
  int n_errors = 0;

  int          lat;
  int          rd_cnt, wr_cnt;
  logic        err_seen;
  logic [31:0] waddr_seen, wdata_seen;

  always #5 clk = ~clk;

  data_memory_port #(.ADDR_LIMIT(128)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .req_i      (req),
    .we_i       (we),
    .size_i     (size),
    .unsigned_i (uns),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .rdata_o    (rdata),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wdata),
    .mem_read_o (mem_read),
    .mem_write_o(mem_write),
    .mem_data_i (mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (mem_write) mem[mem_addr[6:2]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[6:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issues one request and watches the memory port until done_o (bounded).
  task automatic run_access(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0; rd_cnt = 0; wr_cnt = 0; err_seen = 1'b0;
    waddr_seen = 32'hx; wdata_seen = 32'hx;
    forever begin
      @(negedge clk);
      lat++;
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cnt++; waddr_seen = mem_addr; wdata_seen = mem_wdata;
      end
      if (mem_read && mem_write) check("rd_wr_overlap", 32'd1, 32'd0);
      if (done) begin
        err_seen = err;
        break;
      end
      if (lat >= 10) begin
        check("done_timeout", 32'(lat), 32'd0);
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_rden", {31'b0, mem_read}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    preload(5'd1, 32'h0BAD_F00D);

    run_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_wr_cnt", 32'(wr_cnt), 32'd1);
    check("sw_rd_cnt", 32'(rd_cnt), 32'd0);
    check("sw_waddr", waddr_seen, 32'h10);
    check("sw_wdata", wdata_seen, 32'hDEAD_BEEF);
    check("sw_err", {31'b0, err_seen}, 32'd0);

    run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", rdata, 32'hDEAD_BEEF);

    preload(5'd4, 32'h1122_3344);
    run_access(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_rd_cnt", 32'(rd_cnt), 32'd1);
    check("sb_wdata", wdata_seen, 32'h11AA_3344);
    check("sb_waddr", waddr_seen, 32'h10);
    check("sb_rdata_kept", rdata, 32'hDEAD_BEEF);

    run_access(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    check("lb_lat", 32'(lat), 32'd2);
    check("lb_signed", rdata, 32'hFFFF_FFAA);
    run_access(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    check("lbu", rdata, 32'h0000_00AA);
    run_access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    check("lbu_lane1", rdata, 32'h0000_0033);

    preload(5'd5, 32'h5566_7788);
    run_access(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF_8001);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_wdata", wdata_seen, 32'h8001_7788);
    run_access(1'b0, 2'b01, 1'b0, 32'h16, 32'h0);
    check("lh_signed", rdata, 32'hFFFF_8001);
    run_access(1'b0, 2'b01, 1'b1, 32'h14, 32'h0);
    check("lhu_low", rdata, 32'h0000_7788);
    run_access(1'b0, 2'b01, 1'b0, 32'h16, 32'h0);

    // Error cases: {we, size, addr}
    begin
      logic [34:0] errv [0:4];
      errv[0] = {1'b0, 2'b01, 32'h13};
      errv[1] = {1'b0, 2'b10, 32'h0E};
      errv[2] = {1'b1, 2'b10, 32'h7E};
      errv[3] = {1'b0, 2'b10, 32'h80};
      errv[4] = {1'b0, 2'b11, 32'h04};
      for (int i = 0; i < 5; i++) begin
        run_access(errv[i][34], errv[i][33:32], 1'b0, errv[i][31:0], 32'h1234_5678);
        check($sformatf("err%0d_lat", i), 32'(lat), 32'd1);
        check($sformatf("err%0d_flag", i), {31'b0, err_seen}, 32'd1);
        check($sformatf("err%0d_en", i), 32'(rd_cnt + wr_cnt), 32'd0);
        check($sformatf("err%0d_rdata", i), rdata, 32'hFFFF_8001);
      end
    end

    run_access(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0);
    check("lw_top_err", {31'b0, err_seen}, 32'd0);
    check("lw_top_rdata", rdata, 32'h0);

    // Back-to-back loads with req held high
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h04;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("tp_busy%0d", i), {31'b0, busy}, (i % 3 != 0) ? 32'd1 : 32'd0);
      check($sformatf("tp_done%0d", i), {31'b0, done}, (i % 3 == 2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    req = 1'b0;
    check("tp_rdata", rdata, 32'h0BAD_F00D);

    // Reset while in WR must abort the write
    preload(5'd8, 32'h1234_5678);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("rstwr_in_wr", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstwr_wr_drop", {31'b0, mem_write}, 32'd0);
    check("rstwr_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("rstwr_mem", mem[8], 32'h1234_5678);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_done", {31'b0, done}, 32'd0);
    check("post_rst_err", {31'b0, err}, 32'd0);
    check("post_rst_rdata", rdata, 32'd0);
    check("post_rst_maddr", mem_addr, 32'd0);
    check("post_rst_mdata", mem_wdata, 32'd0);
    check("post_rst_en", {30'b0, mem_read, mem_write}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory_port.md
# data_memory_port

Initiator-side access controller that drives the byte-addressed, little-endian data memory on behalf of the pipeline's MEM stage. It accepts one load/store request at a time, aligns the address to a word boundary, and handles byte and halfword loads with sign or zero extension. It performs sub-word stores as a read-modify-write on the 32-bit memory port and rejects misaligned or out-of-range accesses without touching memory.

## Interface
- ADDR_LIMIT, 128: size of the memory in bytes. An access with byte address + access width > ADDR_LIMIT is out of range.
- clk_i  in  1  clock; every flop updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- req_i  in  1  request strobe. Sampled only in IDLE.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  access width: 00 byte, 01 half, 10 word; 11 is illegal.
- unsigned_i  in  1  load extension: 1 = zero-extend, 0 = sign-extend. Ignored for stores and for word loads.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-justified.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o: the access was misaligned, out of range, or had an illegal size.
- rdata_o  out  32  load result, extended. Held from the done_o cycle until the next accepted load.
- mem_addr_o  out  32  word-aligned address: {addr[31:2],2'b00}.
- mem_data_o  out  32  merged write word.
- mem_read_o  out  1  memory read enable.
- mem_write_o  out  1  memory write enable. Memory commits on the rising edge while this is high.
- mem_data_i  in  32  combinational read data from memory.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- From IDLE with req_i=1, the block captures we_i, size_i, unsigned_i, addr_i and wdata_i into internal registers. The next state is:
  - DONE with err=1 if the request is misaligned, out of range, or size_i=11. Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]≠0.
  - WR for a word store.
  - RD for a load or for a sub-word store.
- RD: mem_read_o=1 and mem_addr_o is driven. At the clock edge the block captures mem_data_i.
  - For a load, it extracts the lane, extends it into rdata_o, and goes to DONE.
  - For a sub-word store, it merges the store data into the captured word and goes to WR.
- Lane select: the byte lane is addr[1:0] (byte k = bits 8k+7:8k). The half lane is addr[1] (bits 15:0 or 31:16).
- Merge rule: only the addressed lane is replaced by wdata_i[7:0] (byte) or wdata_i[15:0] (half). All other bytes are kept from the read.
- WR: mem_write_o=1 and mem_data_o holds the merged word (or wdata_i for a word store). Next state is DONE.
- DONE: done_o=1 and err_o is valid. Next state is IDLE unconditionally. A req_i seen in DONE is ignored; the requester must hold or re-issue it.
- mem_read_o and mem_write_o are never high in the same cycle, and never high in IDLE or DONE.
- rdata_o is updated only by a successful load; stores and errored accesses leave it unchanged.

## Timing
- Reset (asynchronous, active-low rst_i): state=IDLE and every output is 0 (busy_o, done_o, err_o, rdata_o, mem_addr_o, mem_data_o, mem_read_o, mem_write_o).
- Reset mid-operation aborts the access immediately. mem_write_o falls asynchronously, so no write commits, and no done_o is produced.
- All outputs are registered, or decoded from state only. Edge 0 is the accepting edge.
  - Load (any width): RD in cycle 1, DONE with rdata_o valid in cycle 2. Latency is 2.
  - Word store: WR in cycle 1, memory updated at edge 2, DONE in cycle 2.
  - Sub-word store: RD in cycle 1, WR in cycle 2, memory updated at edge 3, DONE in cycle 3.
  - Error: DONE in cycle 1, with no memory enables asserted at any point.
- The earliest next accept is the edge after DONE. Steady-state throughput is one load per 3 cycles.

## Test plan
- Reset with rst_i=0 while in WR: mem_write_o drops in the same cycle and the memory word is unchanged. After release, every output is 0 and state is IDLE.
- Store word 0xDEADBEEF to addr 0x10, then load word from 0x10: mem_write_o pulses one cycle with mem_addr_o=0x10, and rdata_o=0xDEADBEEF with done_o at cycle 2.
- Memory at 0x10 = 0x11223344; store byte 0xAA to 0x12: read then write of 0x11AA3344, with done_o at cycle 3. Then load byte from 0x12 signed gives 0xFFFFFFAA, and unsigned gives 0x000000AA.
- Store half 0x8001 to 0x16 (word 0x14 pre-filled with 0x55667788): the written word is 0x80017788. A signed half load from 0x16 gives 0xFFFF8001.
- Load half from 0x13, load word from 0x0E, and store word to 0x7E with ADDR_LIMIT=128: each gives err_o=1 with done_o at cycle 1, no mem_read_o or mem_write_o, and rdata_o unchanged.
- Hold req_i high continuously with a load to 0x04: requests are accepted only in IDLE, done_o pulses every 3 cycles, and busy_o is low exactly on the accepting cycles.
